// File: rtl/rom_download_ctrl.sv
`timescale 1ns/1ps
// ROM download bridge: queues data_io bytes and writes each one to SDRAM port1 (CPU ROM) or
// port2 (gfx ROM) with a toggle handshake; raises rom_loaded once the last byte is acknowledged.
module rom_download_ctrl #(
    parameter logic [24:0] GFX_BASE   = 25'h00C000,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  ROM_INDEX  = 8'd0
) (
    input  logic        clk_49m,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [22:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        port_we,
    output logic        busy,
    output logic        overflow,
    output logic        rom_loaded,
    input  logic        core_reset_n,
    output logic        core_run_n
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = FIFO_DEPTH[PTR_W:0];

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;
    state_e state_q, state_d;

    logic [32:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             wr_q, dl_q, init_q, sel_q, done_pending_q;
    logic             capture, push, pop, fifo_empty, fifo_full;
    logic             req_done, issue1, issue2, head_gfx;
    logic [24:0]      head_addr;
    logic [7:0]       head_data;
    logic [23:0]      gfx_off;

    assign capture    = ioctl_wr & ~wr_q & ioctl_download & (ioctl_index == ROM_INDEX);
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_COUNT);
    assign push       = capture & ~fifo_full;
    assign head_addr  = fifo_mem[rd_ptr_q][32:8];
    assign head_data  = fifo_mem[rd_ptr_q][7:0];
    assign head_gfx   = (head_addr >= GFX_BASE);
    // Bit 24 of the offset never reaches the port, so subtract on 24 bits.
    assign gfx_off    = head_addr[23:0] - GFX_BASE[23:0];
    assign port_we    = ioctl_download | busy;
    assign core_run_n = core_reset_n & rom_loaded;

    always_ff @(posedge clk_49m) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {ioctl_addr, ioctl_dout};
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wr_q     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wr_q <= ioctl_wr;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            if (capture && fifo_full) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (!init_q && !fifo_empty) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (req_done) state_d = fifo_empty ? StIdle : StIssue;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop      = (state_q == StIssue);
        issue1   = pop & ~head_gfx;
        issue2   = pop & head_gfx;
        busy     = !fifo_empty || (state_q != StIdle);
        req_done = sel_q ? (port2_req == port2_ack) : (port1_req == port1_ack);
    end

    // A write issued before reset may still be acked, so req follows ack on the first cycle.
    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            init_q    <= 1'b1;
            sel_q     <= 1'b0;
            port1_req <= 1'b0;
            port1_a   <= '0;
            port1_ds  <= '0;
            port1_d   <= '0;
            port2_req <= 1'b0;
            port2_a   <= '0;
            port2_ds  <= '0;
            port2_d   <= '0;
        end else begin
            init_q <= 1'b0;
            if (init_q) begin
                port1_req <= port1_ack;
                port2_req <= port2_ack;
            end
            if (issue1) begin
                sel_q     <= 1'b0;
                port1_req <= ~port1_req;
                port1_a   <= head_addr[23:1];
                port1_ds  <= {head_addr[0], ~head_addr[0]};
                port1_d   <= {head_data, head_data};
            end
            if (issue2) begin
                sel_q     <= 1'b1;
                port2_req <= ~port2_req;
                port2_a   <= {gfx_off[23:15], gfx_off[13:0]};
                port2_ds  <= {~gfx_off[14], gfx_off[14]};
                port2_d   <= {head_data, head_data};
            end
        end
    end

    always_ff @(posedge clk_49m or negedge reset) begin
        if (!reset) begin
            dl_q           <= 1'b0;
            done_pending_q <= 1'b0;
            rom_loaded     <= 1'b0;
        end else begin
            dl_q <= ioctl_download;
            if (ioctl_download && !dl_q) begin
                done_pending_q <= 1'b0;
                rom_loaded     <= 1'b0;
            end else begin
                if (!ioctl_download && dl_q) begin
                    done_pending_q <= 1'b1;
                end
                if (done_pending_q && !busy) begin
                    done_pending_q <= 1'b0;
                    rom_loaded     <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_download_ctrl.sv
`timescale 1ns/1ps
// Directed bench for rom_download_ctrl: an SDRAM ack responder with programmable latency and a
// write monitor feed per-scenario checks against hand-computed port values.
module tb_rom_download_ctrl;

    logic        clk_49m = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        port1_req, port1_ack, port2_req, port2_ack;
    logic [22:0] port1_a, port2_a;
    logic [1:0]  port1_ds, port2_ds;
    logic [15:0] port1_d, port2_d;
    logic        port_we, busy, overflow, rom_loaded, core_reset_n, core_run_n;

    typedef struct {
        logic [1:0]  port;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } wr_t;

    wr_t commits[$];
    int  n_cmp = 0;
    int  n_err = 0;
    int  ack_delay = 2;
    bit  ack_hold = 1'b0;
    bit  mon_en = 1'b1;

    always #5 clk_49m = ~clk_49m;

    rom_download_ctrl #(
        .GFX_BASE  (25'h00C000),
        .FIFO_DEPTH(4),
        .ROM_INDEX (8'd0)
    ) dut (
        .clk_49m       (clk_49m),
        .reset         (reset),
        .ioctl_download(ioctl_download),
        .ioctl_index   (ioctl_index),
        .ioctl_wr      (ioctl_wr),
        .ioctl_addr    (ioctl_addr),
        .ioctl_dout    (ioctl_dout),
        .port1_req     (port1_req),
        .port1_ack     (port1_ack),
        .port1_a       (port1_a),
        .port1_ds      (port1_ds),
        .port1_d       (port1_d),
        .port2_req     (port2_req),
        .port2_ack     (port2_ack),
        .port2_a       (port2_a),
        .port2_ds      (port2_ds),
        .port2_d       (port2_d),
        .port_we       (port_we),
        .busy          (busy),
        .overflow      (overflow),
        .rom_loaded    (rom_loaded),
        .core_reset_n  (core_reset_n),
        .core_run_n    (core_run_n)
    );

    // SDRAM responder: ack follows req ack_delay cycles after a mismatch appears.
    initial begin
        int c1, c2;
        c1 = 0;
        c2 = 0;
        port1_ack = 1'b0;
        port2_ack = 1'b0;
        forever begin
            @(negedge clk_49m);
            if (!ack_hold && port1_req !== port1_ack) begin
                if (c1 >= ack_delay) begin port1_ack = port1_req; c1 = 0; end
                else c1++;
            end else c1 = 0;
            if (!ack_hold && port2_req !== port2_ack) begin
                if (c2 >= ack_delay) begin port2_ack = port2_req; c2 = 0; end
                else c2++;
            end else c2 = 0;
        end
    end

    // Records the port fields each time a req toggles.
    initial begin
        logic p1p, p2p;
        wr_t  e;
        p1p = 1'b0;
        p2p = 1'b0;
        forever begin
            @(negedge clk_49m);
            if (mon_en && port1_req !== p1p) begin
                e.port = 2'd1; e.a = port1_a; e.ds = port1_ds; e.d = port1_d;
                commits.push_back(e);
            end
            if (mon_en && port2_req !== p2p) begin
                e.port = 2'd2; e.a = port2_a; e.ds = port2_ds; e.d = port2_d;
                commits.push_back(e);
            end
            p1p = port1_req;
            p2p = port2_req;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary, required completion");
        $fatal(1);
    end

    function automatic logic [42:0] pk(input wr_t e);
        return {e.port, e.a, e.ds, e.d};
    endfunction

    function automatic logic [42:0] got(input int i);
        if (i < commits.size()) return pk(commits[i]);
        return 'x;
    endfunction

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk_49m);
    endtask

    task automatic strobe(input logic [24:0] a, input logic [7:0] d, input int hold = 1);
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        tick(hold);
        ioctl_wr   = 1'b0;
        tick(1);
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int i;
        i = 0;
        while ((busy !== 1'b0 || port1_req !== port1_ack || port2_req !== port2_ack) && i < budget) begin
            tick(1);
            i++;
        end
        n_cmp++;
        if (i >= budget) begin
            n_err++;
            $display("FAIL %s idle timeout: busy=%b after %0d cycles, required 0", tag, busy, i);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
        ioctl_addr = '0; ioctl_dout = '0; core_reset_n = 1'b1;
        tick(3);
        n_cmp++;
        if ({port1_req, port2_req} !== 2'b00) begin
            n_err++; $display("FAIL reset reqs: got %b, required 00", {port1_req, port2_req});
        end
        n_cmp++;
        if ({port1_a, port1_ds, port1_d} !== 41'd0) begin
            n_err++; $display("FAIL reset port1: got %h, required 0", {port1_a, port1_ds, port1_d});
        end
        n_cmp++;
        if ({port2_a, port2_ds, port2_d} !== 41'd0) begin
            n_err++; $display("FAIL reset port2: got %h, required 0", {port2_a, port2_ds, port2_d});
        end
        n_cmp++;
        if ({port_we, busy, overflow, rom_loaded, core_run_n} !== 5'b0) begin
            n_err++;
            $display("FAIL reset flags: got %b, required 00000",
                     {port_we, busy, overflow, rom_loaded, core_run_n});
        end
        reset = 1'b1;
        tick(2);
        n_cmp++;
        if ({port1_req, port2_req, busy} !== 3'b000) begin
            n_err++; $display("FAIL reset release: got %b, required 000", {port1_req, port2_req, busy});
        end
    endtask

    task automatic test_cpu_byte();
        commits.delete();
        ioctl_download = 1'b1;
        tick(1);
        n_cmp++;
        if (port_we !== 1'b1) begin
            n_err++; $display("FAIL cpu port_we: got %b, required 1", port_we);
        end
        strobe(25'h000003, 8'h5A);
        wait_idle(100, "cpu");
        n_cmp++;
        if (commits.size() !== 1) begin
            n_err++; $display("FAIL cpu count: got %0d writes, required 1", commits.size());
        end
        n_cmp++;
        if (got(0) !== {2'd1, 23'h000001, 2'b10, 16'h5A5A}) begin
            n_err++; $display("FAIL cpu write: got %h, required %h", got(0),
                              {2'd1, 23'h000001, 2'b10, 16'h5A5A});
        end
        ioctl_download = 1'b0;
        tick(3);
        n_cmp++;
        if ({rom_loaded, core_run_n, port_we} !== 3'b110) begin
            n_err++;
            $display("FAIL cpu done: got %b, required 110", {rom_loaded, core_run_n, port_we});
        end
    endtask

    task automatic test_gfx();
        logic [24:0] ga [5];
        logic [7:0]  gd [5];
        logic [42:0] ge [5];
        ga = '{25'h010005, 25'h00C005, 25'h00BFFF, 25'h00C000, 25'h024003};
        gd = '{8'h77, 8'h78, 8'h11, 8'h22, 8'h33};
        ge = '{{2'd2, 23'h000005, 2'b01, 16'h7777},
               {2'd2, 23'h000005, 2'b10, 16'h7878},
               {2'd1, 23'h005FFF, 2'b10, 16'h1111},
               {2'd2, 23'h000000, 2'b10, 16'h2222},
               {2'd2, 23'h00C003, 2'b10, 16'h3333}};
        commits.delete();
        ioctl_download = 1'b1;
        tick(2);
        n_cmp++;
        if ({rom_loaded, core_run_n} !== 2'b00) begin
            n_err++; $display("FAIL gfx restart: got %b, required 00", {rom_loaded, core_run_n});
        end
        for (int i = 0; i < 5; i++) begin
            strobe(ga[i], gd[i]);
            wait_idle(100, "gfx");
        end
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (got(i) !== ge[i]) begin
                n_err++; $display("FAIL gfx[%0d]: got %h, required %h", i, got(i), ge[i]);
            end
        end
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL gfx overflow: got %b, required 0", overflow);
        end
        ioctl_download = 1'b0;
        tick(3);
    endtask

    task automatic test_held_wr();
        commits.delete();
        ioctl_download = 1'b1;
        tick(1);
        strobe(25'h000010, 8'hA5, 3);
        wait_idle(100, "held");
        ioctl_index = 8'd1;
        strobe(25'h000012, 8'hC3);
        tick(8);
        ioctl_index = 8'd0;
        n_cmp++;
        if (commits.size() !== 1) begin
            n_err++; $display("FAIL held count: got %0d writes, required 1", commits.size());
        end
        n_cmp++;
        if (got(0) !== {2'd1, 23'h000008, 2'b01, 16'hA5A5}) begin
            n_err++; $display("FAIL held write: got %h, required %h", got(0),
                              {2'd1, 23'h000008, 2'b01, 16'hA5A5});
        end
        ioctl_download = 1'b0;
        tick(3);
    endtask

    task automatic test_load_complete();
        int  i;
        bit  early;
        commits.delete();
        ack_delay = 10;
        ioctl_download = 1'b1;
        tick(2);
        n_cmp++;
        if ({rom_loaded, core_run_n} !== 2'b00) begin
            n_err++; $display("FAIL load restart: got %b, required 00", {rom_loaded, core_run_n});
        end
        strobe(25'h000020, 8'h01);
        strobe(25'h000021, 8'h02);
        ioctl_download = 1'b0;
        i = 0;
        early = 1'b0;
        while (busy !== 1'b0 && i < 200) begin
            if (rom_loaded !== 1'b0) early = 1'b1;
            tick(1);
            i++;
        end
        n_cmp++;
        if (i >= 200 || early || rom_loaded !== 1'b0) begin
            n_err++;
            $display("FAIL load early: got loaded-while-busy=%b loaded=%b cycles=%0d, required 0 0 <200",
                     early, rom_loaded, i);
        end
        tick(1);
        n_cmp++;
        if ({rom_loaded, core_run_n, port_we} !== 3'b110) begin
            n_err++;
            $display("FAIL load done: got %b, required 110", {rom_loaded, core_run_n, port_we});
        end
        core_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (core_run_n !== 1'b0) begin
            n_err++; $display("FAIL load core_reset: got %b, required 0", core_run_n);
        end
        core_reset_n = 1'b1;
        n_cmp++;
        if (got(0) !== {2'd1, 23'h000010, 2'b01, 16'h0101} ||
            got(1) !== {2'd1, 23'h000010, 2'b10, 16'h0202} || commits.size() !== 2) begin
            n_err++; $display("FAIL load order: got %h %h (n=%0d), required %h %h", got(0), got(1),
                              commits.size(), {2'd1, 23'h000010, 2'b01, 16'h0101},
                              {2'd1, 23'h000010, 2'b10, 16'h0202});
        end
        tick(1);
    endtask

    task automatic test_overflow();
        commits.delete();
        ack_delay = 20;
        ioctl_download = 1'b1;
        tick(1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_err++; $display("FAIL ovf before: got %b, required 0", overflow);
        end
        for (int i = 0; i < 6; i++) begin
            strobe(25'h000100 + 25'(i), 8'h30 + 8'(i));
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_err++; $display("FAIL ovf flag: got %b, required 1", overflow);
        end
        wait_idle(500, "ovf");
        tick(5);
        n_cmp++;
        if (commits.size() !== 5) begin
            n_err++; $display("FAIL ovf count: got %0d writes, required 5", commits.size());
        end
        for (int i = 0; i < 5; i++) begin
            logic [42:0] exp;
            logic [7:0]  b;
            b   = 8'h30 + 8'(i);
            exp = {2'd1, 23'h000080 + 23'(i / 2), ((i % 2) != 0) ? 2'b10 : 2'b01, b, b};
            n_cmp++;
            if (got(i) !== exp) begin
                n_err++; $display("FAIL ovf[%0d]: got %h, required %h", i, got(i), exp);
            end
        end
        ioctl_download = 1'b0;
        ack_delay = 2;
        tick(3);
    endtask

    task automatic test_reset_mid_write();
        ack_delay = 2;
        ioctl_download = 1'b1;
        tick(1);
        if (port1_ack !== 1'b1) begin
            strobe(25'h000002, 8'h44);
            wait_idle(100, "rst prep");
        end
        ack_hold = 1'b1;
        strobe(25'h000004, 8'h55);
        strobe(25'h000006, 8'h66);
        tick(2);
        n_cmp++;
        if ({port1_req, port1_ack, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL rst outstanding: got req/ack/busy=%b, required 011",
                     {port1_req, port1_ack, busy});
        end
        mon_en = 1'b0;
        reset  = 1'b0;
        tick(1);
        n_cmp++;
        if ({port1_req, busy, overflow} !== 3'b000) begin
            n_err++; $display("FAIL rst asserted: got %b, required 000", {port1_req, busy, overflow});
        end
        reset = 1'b1;
        tick(1);
        n_cmp++;
        if (port1_req !== port1_ack) begin
            n_err++; $display("FAIL rst resync: got req=%b, required ack=%b", port1_req, port1_ack);
        end
        tick(10);
        n_cmp++;
        if ({port1_req, busy, port2_req === port2_ack} !== 3'b101) begin
            n_err++; $display("FAIL rst quiet: got req/busy/p2eq=%b, required 101",
                              {port1_req, busy, port2_req === port2_ack});
        end
        ack_hold = 1'b0;
        mon_en   = 1'b1;
        ioctl_download = 1'b0;
        tick(3);
    endtask

    initial begin
        test_reset();
        test_cpu_byte();
        test_gfx();
        test_held_wr();
        test_load_complete();
        test_overflow();
        test_reset_mid_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
